// File: rtl/weights_prefetch_ram.sv
// weights_prefetch_ram
//   Streams a configurable number of fixed-length DDR bursts, starting at a
//   programmable base address, through an internal first-word-fall-through
//   FIFO to a PE weight port. Requests are throttled by credits so a
//   compliant DDR never overflows the FIFO.
//
// Ports
//   s_clk, s_rst                     clock, synchronous active-high reset
//   cfg_base_addr/num_bursts/repeat  weight-set configuration, sampled on cfg_start
//   cfg_start                        one-cycle start pulse (ignored unless IDLE)
//   rd_burst_*                       DDR read burst interface (req held until finish)
//   o_weight_out/o_weight_valid      FIFO head word / FIFO non-empty
//   weight_ready                     PE accepts the head word
//   load_w_finish                    flush / abort pulse
//   o_busy, o_done, o_overflow       status: not IDLE, set completed, sticky overflow
//
// state | meaning
// IDLE  | waiting for cfg_start
// ISSUE | waiting for FIFO credit before requesting the next burst
// FETCH | burst requested, accepting beats until rd_burst_finish
// DRAIN | all bursts fetched, waiting for the PE to empty the FIFO
// ABORT | flushed mid-burst, discarding beats until rd_burst_finish
module weights_prefetch_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_SIZE  = 32,
    parameter int LEN_WIDTH  = 10,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic [ADDR_SIZE-1:0]  cfg_base_addr,
    input  logic [CNT_WIDTH-1:0]  cfg_num_bursts,
    input  logic                  cfg_repeat,
    input  logic                  cfg_start,
    input  logic [DATA_WIDTH-1:0] rd_burst_data,
    output logic [ADDR_SIZE-1:0]  rd_burst_addr,
    output logic [LEN_WIDTH-1:0]  rd_burst_len,
    output logic                  rd_burst_req,
    input  logic                  rd_burst_valid,
    input  logic                  rd_burst_finish,
    output logic [DATA_WIDTH-1:0] o_weight_out,
    output logic                  o_weight_valid,
    input  logic                  weight_ready,
    input  logic                  load_w_finish,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = AW + 2;
    localparam logic [ADDR_SIZE-1:0] BURST_BYTES = ADDR_SIZE'(BURST_LEN * DATA_WIDTH / 8);

    typedef enum logic [2:0] {IDLE, ISSUE, FETCH, DRAIN, ABORT} state_t;

    state_t                 state, next_state;
    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [PW-1:0]          count, inflight;
    logic [ADDR_SIZE-1:0]   addr, base_q;
    logic [CNT_WIDTH-1:0]   bursts_left, num_q;
    logic                   repeat_q, req_q, done_q, ovf_q;

    logic                   full, empty, rd_en, wr_en, flush, last_burst, credit_ok;
    logic [CW-1:0]          used;

    assign full       = (count == PW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign rd_en      = !empty && weight_ready;
    assign wr_en      = rd_burst_valid && (state == FETCH) && !full;
    assign last_burst = (bursts_left == CNT_WIDTH'(1));
    // Words already stored plus beats still owed by the outstanding burst.
    assign used       = CW'(count) + CW'(inflight);
    assign credit_ok  = (used + CW'(BURST_LEN)) <= CW'(FIFO_DEPTH);

    always_comb begin
        next_state = state;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (load_w_finish)
                    flush = 1'b1;
                else if (cfg_start && (cfg_num_bursts != '0))
                    next_state = ISSUE;
            end
            ISSUE: begin
                if (load_w_finish) begin
                    flush      = 1'b1;
                    next_state = IDLE;
                end else if (credit_ok) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (load_w_finish) begin
                    flush = 1'b1;
                    // A burst that completes in the same cycle needs no abort wait.
                    next_state = rd_burst_finish ? IDLE : ABORT;
                end else if (rd_burst_finish) begin
                    next_state = (last_burst && !repeat_q) ? DRAIN : ISSUE;
                end
            end
            DRAIN: begin
                if (load_w_finish) begin
                    flush      = 1'b1;
                    next_state = IDLE;
                end else if (empty) begin
                    next_state = IDLE;
                end
            end
            ABORT: begin
                flush = load_w_finish;
                if (rd_burst_finish)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            inflight    <= '0;
            addr        <= '0;
            base_q      <= '0;
            bursts_left <= '0;
            num_q       <= '0;
            repeat_q    <= 1'b0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state  <= next_state;
            // Request stays up for the whole burst, including an aborted one.
            req_q  <= (next_state == FETCH) || (next_state == ABORT);
            done_q <= (state == DRAIN) && empty && !load_w_finish;
            if (rd_burst_valid && (state == FETCH) && full)
                ovf_q <= 1'b1;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr + 1'b1;
                if (rd_en)
                    rd_ptr <= rd_ptr + 1'b1;
                if (wr_en && !rd_en)
                    count <= count + 1'b1;
                else if (!wr_en && rd_en)
                    count <= count - 1'b1;
            end

            if ((state == ISSUE) && (next_state == FETCH))
                inflight <= PW'(BURST_LEN);
            else if (((state == FETCH) || (state == ABORT)) && rd_burst_finish)
                inflight <= '0;
            else if (wr_en && (inflight != '0))
                inflight <= inflight - 1'b1;

            if ((state == IDLE) && (next_state == ISSUE)) begin
                base_q      <= cfg_base_addr;
                num_q       <= cfg_num_bursts;
                repeat_q    <= cfg_repeat;
                addr        <= cfg_base_addr;
                bursts_left <= cfg_num_bursts;
            end else if ((state == FETCH) && rd_burst_finish && !load_w_finish) begin
                if (last_burst && repeat_q) begin
                    addr        <= base_q;
                    bursts_left <= num_q;
                end else begin
                    addr        <= addr + BURST_BYTES;
                    bursts_left <= bursts_left - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge s_clk) begin
        if (wr_en)
            mem[wr_ptr] <= rd_burst_data;
    end

    assign rd_burst_addr  = addr;
    assign rd_burst_len   = LEN_WIDTH'(BURST_LEN);
    assign rd_burst_req   = req_q;
    assign o_weight_out   = mem[rd_ptr];
    assign o_weight_valid = !empty;
    assign o_busy         = (state != IDLE);
    assign o_done         = done_q;
    assign o_overflow     = ovf_q;
endmodule

// File: doc/weights_prefetch_ram.md
Name: weights_prefetch_ram

Overview:
Parametrised DDR-to-PE weight streamer; the next generation of the conv-layer weight buffer. Fetches a configurable number of fixed-length DDR bursts from a programmable base address into an internal FIFO and presents them to a PE array with a valid/ready handshake. Uses credit-based request throttling, optional repeat (wrap) mode, done signalling, and a safe flush that drains any in-flight burst. One instance per conv layer; sits between the DDR read arbiter and the layer's PE weight port.

Parameters:
DATA_WIDTH, 64, DDR beat and weight word width (bits; multiple of 8)
ADDR_SIZE, 32, DDR byte address width
LEN_WIDTH, 10, burst-length field width
BURST_LEN, 8, beats per DDR burst (1..FIFO_DEPTH)
FIFO_DEPTH, 64, internal FIFO words (power of 2, >= BURST_LEN)
CNT_WIDTH, 16, width of burst-count configuration

Ports:
s_clk  in  1  clock (DDR user clock)
s_rst  in  1  synchronous active-high reset
cfg_base_addr  in  ADDR_SIZE  first burst byte address; sampled on cfg_start
cfg_num_bursts  in  CNT_WIDTH  bursts per weight set (0 = start ignored); sampled on cfg_start
cfg_repeat  in  1  1: wrap to base after last burst and continue until flush; sampled on cfg_start
cfg_start  in  1  one-cycle start pulse; ignored unless IDLE
rd_burst_data  in  DATA_WIDTH  DDR read data
rd_burst_addr  out  ADDR_SIZE  DDR burst address
rd_burst_len  out  LEN_WIDTH  constant BURST_LEN
rd_burst_req  out  1  request, held until rd_burst_finish
rd_burst_valid  in  1  data beat valid
rd_burst_finish  in  1  burst complete pulse
o_weight_out  out  DATA_WIDTH  FIFO head word
o_weight_valid  out  1  FIFO non-empty
weight_ready  in  1  PE accepts word
load_w_finish  in  1  flush / abort pulse
o_busy  out  1  not IDLE
o_done  out  1  one-cycle pulse: all bursts of a non-repeat set fetched and FIFO drained
o_overflow  out  1  sticky error: beat arrived while FIFO full

Behaviour:
- Reset (s_rst at clock edge): state IDLE; FIFO empty; rd_burst_req=0, rd_burst_addr=0, o_weight_valid=0, o_busy=0, o_done=0, o_overflow=0; counters 0. Reset wins over every other input, including mid-burst.
- FIFO: register array, first-word-fall-through. o_weight_valid = ~empty; o_weight_out = head word. Transfer = o_weight_valid & weight_ready. Write = rd_burst_valid in FETCH and ~full. Simultaneous read+write keeps occupancy unchanged; read on empty is impossible; write when full drops the beat and sets o_overflow.
- Credit: free = FIFO_DEPTH - occupancy - inflight, where inflight = BURST_LEN on request issue, decremented by 1 per accepted beat, forced to 0 on rd_burst_finish. Request only if free >= BURST_LEN, so overflow never occurs with a compliant DDR.
- FSM states IDLE, ISSUE, FETCH, DRAIN, ABORT:
  IDLE: on cfg_start with cfg_num_bursts!=0, latch the config; addr=cfg_base_addr; bursts_left=cfg_num_bursts; go ISSUE.
  ISSUE: when credit is sufficient, assert rd_burst_req (registered, next cycle); go FETCH.
  FETCH: hold rd_burst_req until rd_burst_finish. On finish: req drops the same edge; addr += BURST_LEN*DATA_WIDTH/8 (mod 2^ADDR_SIZE); bursts_left-1. If bursts_left was 1: if repeat, addr=base and bursts_left=num, go ISSUE; else go DRAIN. Otherwise go ISSUE.
  DRAIN: when FIFO is empty, pulse o_done and go IDLE.
- load_w_finish in ISSUE/DRAIN/IDLE: FIFO flushed the same edge, go IDLE, no o_done. In FETCH: go ABORT; FIFO flushed, and later beats of this burst are discarded (not written). ABORT holds rd_burst_req until rd_burst_finish, then goes IDLE.
- load_w_finish and cfg_start in the same cycle: flush takes priority; start ignored.
- The first word is visible on o_weight_out 1 cycle after the first beat is written.

Test Plan:
- BURST_LEN=8, DEPTH=64, num=3, base=0x1000, PE always ready -> addrs 0x1000,0x1040,0x1080; 24 words out in order; o_done pulses once after the last read; back to IDLE.
- weight_ready=0 throughout, num=10 -> exactly 8 bursts issued (64 words), no o_overflow; then release ready -> remaining 2 bursts issue, 80 words total.
- cfg_repeat=1, num=2, base=0x2000 -> addrs 0x2000,0x2040,0x2000,0x2040...; o_done never; load_w_finish -> IDLE, o_weight_valid=0 next cycle.
- load_w_finish at beat 3 of a burst -> remaining 5 beats discarded, req held until finish, FIFO empty, IDLE, no o_done.
- Simultaneous write+read at FIFO occupancy 63 and at 1 -> occupancy unchanged, data order intact; forced write when full -> o_overflow=1 sticky until s_rst.
- s_rst mid-FETCH -> all outputs return to reset values the next cycle; a new cfg_start works normally.
